exc_irq_ctrl: RTL
=================

# exc_irq_ctrl

Parametrised exception/interrupt controller for the single-cycle LEGv8 core with exceptions. It generalises the single external-IRQ exception path to N_IRQ maskable, latched interrupt lines with fixed priority and a registered request/acknowledge handshake. It blocks further interrupts while a handler runs until ERet, and reports double faults. It sits between the main decoder (NotAnInstr, ERet) and the datapath exception logic (Exc, EStatus, ExcAck).

## Interface
- N_IRQ, default 4: number of external interrupt lines; legal range 1..8.
- ID_W, default $clog2(N_IRQ) (min 1): width of irq_id.

- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  reset is synchronous and active-low; clears all state on a clk edge where it is low.
- irq_i  in  N_IRQ  external interrupt requests; bit 0 has the highest priority.
- mask_we  in  1  write enable for the mask register.
- mask_wdata  in  N_IRQ  new mask value; 1 = channel masked.
- not_an_instr  in  1  invalid-opcode flag from the main decoder (current instruction).
- eret  in  1  ERet decoded for the current instruction.
- exc_ack  in  1  datapath took the exception this cycle (PC redirected to vector).
- exc  out  1  exception request to the datapath.
- estatus  out  4  cause code (see Operation).
- irq_id  out  ID_W  index of the granted IRQ; valid while state is REQ or HANDLER after an IRQ.
- irq_ack  out  N_IRQ  one-hot, 1-cycle acknowledge to the granted source.
- in_handler  out  1  high while state is HANDLER.

## Operation
- Cause codes: 4'b0000 none; 4'b0010 invalid instruction; 4'b1000|id external IRQ id; 4'b1111 double fault (invalid instruction inside handler).
- pending[N_IRQ] register: set per channel as described under Configuration; bit id cleared when irq_ack[id] pulses. Set and clear in the same cycle: set wins.
- mask register: written at any state on mask_we. Masking only gates new grants; a request already in REQ is not withdrawn.
- FSM states IDLE, REQ, HANDLER.
  - IDLE: if (pending & ~mask) != 0, capture the lowest set index into id_q and go to REQ.
  - REQ: exc=1 and estatus=4'b1000|id_q. On exc_ack, pulse irq_ack[id_q], clear pending[id_q], and go to HANDLER.
  - HANDLER: IRQs are not granted; pending keeps accumulating. On eret, go to IDLE.
- Synchronous exceptions:
  - not_an_instr in IDLE or REQ drives exc=1 and estatus=4'b0010 combinationally and overrides the IRQ code.
  - With exc_ack in that cycle, the state goes to HANDLER and id_q/pending are unchanged. A REQ in progress is abandoned; it is re-granted from pending after ERet.
  - not_an_instr in HANDLER drives exc=1 and estatus=4'b1111; with exc_ack the state stays HANDLER.
- estatus when exc=0: the code of the last taken exception (registered cause_q), or 4'b0000 after reset.
- eret outside HANDLER: ignored.

## Timing
- Reset values: state IDLE, pending 0, mask 0, id_q 0, cause_q 0, exc 0, estatus 0, irq_id 0, irq_ack 0, in_handler 0.
- IRQ latency:
  - irq_i sampled high at edge k sets pending.
  - REQ is entered at edge k+1, so exc is high from k+1 until the ack edge.
  - irq_ack is high for exactly the one cycle after the edge where exc_ack was sampled with state REQ.
- exc for not_an_instr is combinational, with zero latency.
- ERet at edge j: the next IRQ can enter REQ at edge j+1 at the earliest.
- Simultaneous IRQs: the lowest index wins and the others remain pending.
- Reset low during REQ or HANDLER: all state is cleared at that edge and no irq_ack is issued.

## Configuration
- EXC_IRQ_EDGE_EN defined: an irq_prev register is added. pending[i] sets on a rising edge of irq_i[i] (irq_i & ~irq_prev). A line held high produces exactly one grant.
- Not defined: level-sensitive. pending[i] sets every cycle irq_i[i] is high, so a line still high after its ack is re-pended on the next edge.

## Structure
- Package exc_pkg holds:
  - the state enum (IDLE/REQ/HANDLER);
  - the estatus code constants (ESTAT_NONE, ESTAT_INV, ESTAT_IRQ_BASE, ESTAT_DFAULT);
  - MAX_IRQ = 8.
- Sub-module prio_enc (parameter N): lowest-index-first priority encoder with an any-valid flag, used for the grant.

## Test plan
- N_IRQ=4: irq_i=4'b0100 for 1 cycle, exc_ack 2 cycles later -> exc rises at edge k+1 with estatus=4'b1010 and irq_id=2, irq_ack=4'b0100 for 1 cycle, in_handler=1.
- irq_i=4'b1010 together -> id 1 granted first; after eret, id 3 granted with estatus=4'b1011.
- mask=4'b0001 with irq_i[0] high -> no exc. Clearing the mask -> grant id 0 on the next cycle.
- In HANDLER, not_an_instr=1 -> exc=1 with estatus=4'b1111; after ack, in_handler stays 1. In IDLE, not_an_instr -> estatus=4'b0010 in the same cycle.
- Reset low while in REQ -> next cycle all outputs 0, state IDLE, pending 0.
- With EXC_IRQ_EDGE_EN defined, irq_i[0] held high for 10 cycles -> exactly one irq_ack. Without it, a re-grant follows each eret.

Source files
------------

// File: rtl/exc_irq_ctrl_pkg.sv
// exc_pkg: shared types and constants for the exception/interrupt controller.
//   state_t     - controller FSM states (IDLE / REQ / HANDLER)
//   ESTAT_*     - estatus cause codes driven to the datapath
//   MAX_IRQ     - upper bound on the number of external interrupt lines
//   irq_code()  - builds the external-IRQ cause code from a channel index
package exc_pkg;

  localparam int MAX_IRQ = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HANDLER = 2'd2
  } state_t;

  localparam logic [3:0] ESTAT_NONE     = 4'b0000;
  localparam logic [3:0] ESTAT_INV      = 4'b0010;
  localparam logic [3:0] ESTAT_IRQ_BASE = 4'b1000;
  localparam logic [3:0] ESTAT_DFAULT   = 4'b1111;

  // IRQ cause is 4'b1id: the low three bits carry the channel index.
  function automatic logic [3:0] irq_code(input logic [2:0] id);
    return ESTAT_IRQ_BASE | {1'b0, id};
  endfunction

endpackage

// File: rtl/exc_irq_ctrl_if.sv
// exc_irq_ctrl_if: bundles the decoder/datapath/IRQ-source signals of the
// exception controller.
//   slave  - the controller side (exc_irq_ctrl)
//   master - the environment side (decoder, datapath, interrupt sources)
// Signals:
//   irq_i, mask_we, mask_wdata, not_an_instr, eret, exc_ack : env -> ctrl
//   exc, estatus, irq_id, irq_ack, in_handler               : ctrl -> env
interface exc_irq_ctrl_if #(
  parameter int N_IRQ = 4,
  parameter int ID_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
);
  logic [N_IRQ-1:0] irq_i;
  logic             mask_we;
  logic [N_IRQ-1:0] mask_wdata;
  logic             not_an_instr;
  logic             eret;
  logic             exc_ack;
  logic             exc;
  logic [3:0]       estatus;
  logic [ID_W-1:0]  irq_id;
  logic [N_IRQ-1:0] irq_ack;
  logic             in_handler;

  modport slave (
    input  irq_i, mask_we, mask_wdata, not_an_instr, eret, exc_ack,
    output exc, estatus, irq_id, irq_ack, in_handler
  );

  modport master (
    output irq_i, mask_we, mask_wdata, not_an_instr, eret, exc_ack,
    input  exc, estatus, irq_id, irq_ack, in_handler
  );
endinterface

// File: rtl/exc_irq_ctrl_prio_enc.sv
// prio_enc: lowest-index-first priority encoder.
//   i_req  in  N   request vector
//   o_idx  out IW  index of the lowest set bit (0 when none set)
//   o_vld  out 1   any request set
module prio_enc #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  output logic [IW-1:0] o_idx,
  output logic          o_vld
);
  // Scan high to low so the last hit written is the lowest index.
  always_comb begin
    o_idx = '0;
    o_vld = |i_req;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = IW'(i);
    end
  end
endmodule

// File: rtl/exc_irq_ctrl.sv
// exc_irq_ctrl: N_IRQ-line maskable, latched, fixed-priority interrupt and
// synchronous-exception controller for the single-cycle LEGv8 core.
// Ports:
//   clk    in  clock, all state on rising edge
//   reset  in  synchronous, active-low
//   bus    exc_irq_ctrl_if.slave (irq_i, mask_*, not_an_instr, eret,
//          exc_ack in; exc, estatus, irq_id, irq_ack, in_handler out)
// Build option: define EXC_IRQ_EDGE_EN to latch pending on rising edges of
// irq_i instead of while irq_i is high.
module exc_irq_ctrl
  import exc_pkg::*;
#(
  parameter int N_IRQ = 4,
  parameter int ID_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic            clk,
  input  logic            reset,
  exc_irq_ctrl_if.slave   bus
);

  state_t           r_state, w_nxt_state;
  logic [N_IRQ-1:0] r_pending, r_mask, r_irq_ack;
  logic [ID_W-1:0]  r_id;
  logic [3:0]       r_cause;

  logic [N_IRQ-1:0] w_set, w_ack_vec;
  logic [ID_W-1:0]  w_grant_idx;
  logic             w_grant_vld;
  logic             w_exc, w_take, w_irq_take;
  logic [3:0]       w_estatus;

`ifdef EXC_IRQ_EDGE_EN
  logic [N_IRQ-1:0] r_irq_prev;
  always_ff @(posedge clk) begin
    if (!reset) r_irq_prev <= '0;
    else        r_irq_prev <= bus.irq_i;
  end
  assign w_set = bus.irq_i & ~r_irq_prev;
`else
  assign w_set = bus.irq_i;
`endif

  prio_enc #(.N(N_IRQ), .IW(ID_W)) u_prio (
    .i_req (r_pending & ~r_mask),
    .o_idx (w_grant_idx),
    .o_vld (w_grant_vld)
  );

  // An IRQ is only acknowledged when the datapath takes the IRQ itself; a
  // coincident invalid instruction wins and the IRQ stays pending.
  assign w_take     = w_exc & bus.exc_ack;
  assign w_irq_take = (r_state == REQ) & bus.exc_ack & ~bus.not_an_instr;
  assign w_ack_vec  = w_irq_take ? (N_IRQ'(1) << r_id) : '0;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nxt_state;
  end

  // FSM: next state
  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      IDLE: begin
        if (bus.not_an_instr && bus.exc_ack) w_nxt_state = HANDLER;
        else if (w_grant_vld)                w_nxt_state = REQ;
      end
      REQ:     if (bus.exc_ack) w_nxt_state = HANDLER;
      HANDLER: if (bus.eret && !bus.not_an_instr) w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
  end

  // FSM: outputs. Invalid instruction overrides any IRQ code with zero latency.
  always_comb begin
    w_exc     = 1'b0;
    w_estatus = r_cause;
    if (bus.not_an_instr) begin
      w_exc     = 1'b1;
      w_estatus = (r_state == HANDLER) ? ESTAT_DFAULT : ESTAT_INV;
    end else if (r_state == REQ) begin
      w_exc     = 1'b1;
      w_estatus = irq_code(3'(r_id));
    end
  end

  // Datapath registers. Pending set wins over the ack clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pending <= '0;
      r_mask    <= '0;
      r_id      <= '0;
      r_cause   <= ESTAT_NONE;
      r_irq_ack <= '0;
    end else begin
      r_pending <= (r_pending & ~w_ack_vec) | w_set;
      r_irq_ack <= w_ack_vec;
      if (bus.mask_we) r_mask <= bus.mask_wdata;
      if (r_state == IDLE && w_nxt_state == REQ) r_id <= w_grant_idx;
      if (w_take) r_cause <= w_estatus;
    end
  end

  assign bus.exc        = w_exc;
  assign bus.estatus    = w_estatus;
  assign bus.irq_id     = r_id;
  assign bus.irq_ack    = r_irq_ack;
  assign bus.in_handler = (r_state == HANDLER);

endmodule
